// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: opcodes, forward encodings, branch FSM states and scoreboard entry type.
package pipeline_hazard_ctrl_pkg;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_STW = 4'b0111;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_AGEX = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;
  typedef enum logic [1:0] {BR_IDLE, BR_WAIT, BR_REDIR} br_state_e;
  typedef struct packed {
    logic       busy;
    logic       is_ld;
    logic [1:0] age;
  } sb_entry_t;
  // Returns {not_ready, sel}; a consumer in ID meets the producer one stage further on in EX.
  function automatic logic [2:0] fwd_lookup(input logic used, input sb_entry_t e);
    logic [1:0] a;
    a = (e.age == 2'd3) ? 2'd3 : e.age + 2'd1;
    return (!used || !e.busy) ? {1'b0, FWD_RF} : {e.is_ld && a == 2'd1, a};
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: 8-entry register scoreboard with issue/clear/age update and two lookup ports.
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  logic [2:0] issue_dr_i,
  input  logic       issue_ld_i,
  input  logic       wb_enable_i,
  input  logic [2:0] dr_wb_i,
  input  logic [2:0] rd1_i,
  input  logic [2:0] rd2_i,
  output logic [3:0] rd1_o,
  output logic [3:0] rd2_o,
  output logic       age0_o
);
  sb_entry_t sb_q [8];
  sb_entry_t sb_d [8];
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      sb_d[r] = sb_q[r];
      if (sb_q[r].busy) begin
        sb_d[r].age = (sb_q[r].age == 2'd3) ? 2'd3 : sb_q[r].age + 2'd1;
        if (wb_enable_i && dr_wb_i == 3'(r) && sb_q[r].age == 2'd3) sb_d[r].busy = 1'b0;
      end
      if (issue_i && issue_dr_i == 3'(r)) sb_d[r] = '{busy: 1'b1, is_ld: issue_ld_i, age: 2'd0};
    end
  end
  always_comb begin
    age0_o = 1'b0;
    for (int r = 0; r < 8; r++) age0_o = age0_o | (sb_q[r].busy && sb_q[r].age == 2'd0);
  end
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < 8; r++) sb_q[r] <= rst_i ? '0 : sb_d[r];
  end
  assign rd1_o = sb_q[rd1_i];
  assign rd2_o = sb_q[rd2_i];
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage interlock, operand forwarding select and branch flush controller.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int BR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [15:0]      ir_i,
  input  logic             ir_valid_i,
  input  logic             wb_enable_i,
  input  logic [2:0]       dr_wb_i,
  input  logic             branch_taken_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic             flush_o,
  output logic [1:0]       fwd_sel1_o,
  output logic [1:0]       fwd_sel2_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  br_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [3:0]       op, e1, e2;
  logic [2:0]       sr2, f1, f2;
  logic             bubble, is_br, is_add, is_ldw, is_stw, use1, use2, age0;
  assign op     = ir_i[15:12];
  assign bubble = !ir_valid_i || ir_i == '0;
  assign is_br  = !bubble && op == OP_BR;
  assign is_add = !bubble && op == OP_ADD;
  assign is_ldw = !bubble && op == OP_LDW;
  assign is_stw = !bubble && op == OP_STW;
  assign use1   = is_add || is_ldw || is_stw;
  assign use2   = is_stw || (is_add && !ir_i[5]);
  assign sr2    = is_stw ? ir_i[11:9] : ir_i[2:0];
  hazard_scoreboard u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issue_i     (issue_o && (is_add || is_ldw)),
    .issue_dr_i  (ir_i[11:9]),
    .issue_ld_i  (is_ldw),
    .wb_enable_i (wb_enable_i),
    .dr_wb_i     (dr_wb_i),
    .rd1_i       (ir_i[8:6]),
    .rd2_i       (sr2),
    .rd1_o       (e1),
    .rd2_o       (e2),
    .age0_o      (age0)
  );
  assign f1          = fwd_lookup(use1, sb_entry_t'(e1));
  assign f2          = fwd_lookup(use2, sb_entry_t'(e2));
  assign fwd_sel1_o  = f1[1:0];
  assign fwd_sel2_o  = f2[1:0];
  // A branch waits until no producer is still in EX so its condition codes are settled.
  assign stall_o     = f1[2] || f2[2] || state_q != BR_IDLE || (is_br && age0);
  assign flush_o     = state_q == BR_REDIR && branch_taken_i;
  assign issue_o     = !bubble && !stall_o && !flush_o;
  assign stall_cnt_o = stall_cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == BR_IDLE && is_br && issue_o) begin
      state_d = BR_WAIT;
      cnt_d   = 3'(BR_LAT - 1);
    end else if (state_q == BR_WAIT) begin
      state_d = (cnt_q == 3'd0) ? BR_REDIR : BR_WAIT;
      cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
    end else if (state_q == BR_REDIR) begin
      state_d = BR_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    state_q     <= rst_i ? BR_IDLE : state_d;
    cnt_q       <= rst_i ? 3'd0 : cnt_d;
    stall_cnt_q <= rst_i ? '0 : (stall_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench comparing the controller against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;
  localparam int BR_LAT = 2;
  localparam int CNT_W  = 5;
  localparam int SAT    = 31;
  logic clk = 1'b0, rst = 1'b1, ir_valid = 1'b0, wb_en = 1'b0, bt = 1'b0;
  logic [15:0] ir = '0;
  logic [2:0] dr_wb = '0;
  logic stall, issue, flush;
  logic [1:0] f1, f2;
  logic [CNT_W-1:0] scnt;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.BR_LAT(BR_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .ir_valid_i(ir_valid), .wb_enable_i(wb_en),
    .dr_wb_i(dr_wb), .branch_taken_i(bt), .stall_o(stall), .issue_o(issue), .flush_o(flush),
    .fwd_sel1_o(f1), .fwd_sel2_o(f2), .stall_cnt_o(scnt)
  );
  typedef struct {
    int cyc;
    logic stall, issue, flush;
    logic [1:0] f1, f2;
    int scnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  // Reference state: per register, busy/load flag and the cycle its age reads 0.
  bit m_busy[8];
  bit m_ld[8];
  int m_ic[8];
  int cyc = 0, br_left = 0, stall_total = 0;
  bit last_issue, last_flush;
  function automatic void chk(string n, int c, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", n, c, act, want);
    end
  endfunction
  task automatic src(input bit used, input int r, output bit rdy, output logic [1:0] sel);
    int a;
    rdy = 1'b1;
    sel = 2'b00;
    if (used && m_busy[r]) begin
      a = cyc - m_ic[r] + 1;
      if (a > 3) a = 3;
      sel = 2'(a);
      rdy = !(m_ld[r] && a < 2);
    end
  endtask
  task automatic step(input logic [15:0] i, input logic v, input logic w, input logic [2:0] d,
                      input logic b, input logic r);
    exp_t e;
    bit bub, br, add, ldw, stw, r1, r2, any0;
    logic [1:0] s1, s2;
    @(negedge clk);
    ir = i; ir_valid = v; wb_en = w; dr_wb = d; bt = b; rst = r;
    #1;
    last_issue = 1'b0;
    last_flush = 1'b0;
    if (r) begin
      for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
      br_left = 0;
      stall_total = 0;
    end else begin
      bub = !v || i == 16'h0;
      br  = !bub && i[15:12] == 4'd0;
      add = !bub && i[15:12] == 4'd1;
      ldw = !bub && i[15:12] == 4'd6;
      stw = !bub && i[15:12] == 4'd7;
      src(add || ldw || stw, int'(i[8:6]), r1, s1);
      src(stw || (add && !i[5]), stw ? int'(i[11:9]) : int'(i[2:0]), r2, s2);
      any0 = 1'b0;
      for (int k = 0; k < 8; k++) if (m_busy[k] && m_ic[k] == cyc) any0 = 1'b1;
      e.cyc   = cyc;
      e.stall = !r1 || !r2 || br_left > 0 || (br && any0);
      e.flush = br_left == 1 && b;
      e.issue = !bub && !e.stall && !e.flush;
      e.f1    = s1;
      e.f2    = s2;
      e.scnt  = stall_total > SAT ? SAT : stall_total;
      q.push_back(e);
      last_issue = e.issue;
      last_flush = e.flush;
      if (e.stall) stall_total++;
      for (int k = 0; k < 8; k++)
        if (m_busy[k] && w && int'(d) == k && cyc - m_ic[k] >= 3) m_busy[k] = 1'b0;
      if (e.issue && (add || ldw)) begin
        m_busy[i[11:9]] = 1'b1;
        m_ld[i[11:9]]   = ldw;
        m_ic[i[11:9]]   = cyc + 1;
      end
      if (br_left > 0) br_left--;
      else if (e.issue && br) br_left = BR_LAT + 1;
    end
    cyc++;
  endtask
  function automatic logic [15:0] add_r(int d, int a, int b);
    return {4'b0001, 3'(d), 3'(a), 3'b000, 3'(b)};
  endfunction
  function automatic logic [15:0] add_i(int d, int a, int imm);
    return {4'b0001, 3'(d), 3'(a), 1'b1, 5'(imm)};
  endfunction
  function automatic logic [15:0] ldw(int d, int a);
    return {4'b0110, 3'(d), 3'(a), 6'd1};
  endfunction
  function automatic logic [15:0] stw(int s, int a);
    return {4'b0111, 3'(s), 3'(a), 6'd2};
  endfunction
  localparam logic [15:0] BR_ALL = {4'b0000, 3'b111, 9'd5};
  localparam logic [15:0] NOP = 16'h0000;
  function automatic logic [15:0] rand_instr();
    int k, d, a, b;
    k = $urandom_range(0, 9);
    d = $urandom_range(0, 3);
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    return k < 4 ? add_r(d, a, b) : k < 5 ? add_i(d, a, b) : k < 7 ? ldw(d, a) : k < 9 ? stw(b, a) : BR_ALL;
  endfunction
  task automatic issue_instr(input logic [15:0] i);
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step(i, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      ok = last_issue;
    end
    if (!ok) chk("issue_timeout", cyc, 0, 1);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", e.cyc, stall, e.stall);
        chk("issue", e.cyc, issue, e.issue);
        chk("flush", e.cyc, flush, e.flush);
        chk("stall_cnt", e.cyc, scnt, e.scnt);
        if (e.issue) begin
          chk("fwd_sel1", e.cyc, f1, e.f1);
          chk("fwd_sel2", e.cyc, f2, e.f2);
        end
      end
    end
  end
  initial begin
    logic [15:0] cur;
    bit have = 1'b0, v, rs;
    step(NOP, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step(add_r(7, 6, 5), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (4) step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(add_r(1, 2, 3));
    issue_instr(add_r(4, 1, 1));
    repeat (4) step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(ldw(2, 0));
    issue_instr(add_i(5, 2, 1));
    repeat (4) step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(add_r(3, 1, 2));
    step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(add_r(6, 3, 3));
    step(NOP, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    issue_instr(stw(3, 3));
    repeat (4) step(NOP, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(BR_ALL);
    repeat (3) step(add_r(1, 0, 0), 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    issue_instr(BR_ALL);
    repeat (3) step(add_r(1, 0, 0), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step(add_r(2, 0, 0), 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    issue_instr(add_r(1, 0, 0));
    issue_instr(BR_ALL);
    step(NOP, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    step(NOP, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    step(add_r(4, 1, 2), 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if (!have) begin
        cur = rand_instr();
        have = 1'b1;
      end
      v  = $urandom_range(0, 7) != 0;
      rs = $urandom_range(0, 299) == 0;
      step(cur, v, 1'(($urandom_range(0, 1))), 3'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))), rs);
      if (last_issue || last_flush || rs) have = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #3;
    if (q.size() != 0) chk("drain", cyc, q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
